// File: rtl/alu_sequencer.sv
// Sequences one request at a time through an external ALU: registers operands,
// waits the op's latency, captures and qualifies the result, and holds it for handshake.
module alu_sequencer #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [3:0]  req_dst,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_data1,
  output logic [15:0] alu_data2,
  input  logic [15:0] alu_upper,
  input  logic [15:0] alu_lower,
  input  logic        alu_overflow,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_lower,
  output logic [15:0] res_upper,
  output logic        res_upper_vld,
  output logic [3:0]  res_dst,
  output logic [1:0]  res_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_DIV  = 4'b0101;
  localparam logic [3:0] OP_MOVE = 4'b0111;
  localparam logic [3:0] OP_SWAP = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b1011;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  dst_q;

  logic        req_legal;
  logic        req_div0;
  logic [3:0]  req_load;
  logic        cap_ovf;
  logic        cap_uvld;

  always_comb begin
    req_legal = 1'b0;
    req_load  = 4'd0;
    case (req_op)
      OP_ADD, OP_SUB, OP_MOVE, OP_SWAP, OP_AND, OP_OR: req_legal = 1'b1;
      OP_MUL: begin
        req_legal = 1'b1;
        req_load  = MUL_LOAD;
      end
      OP_DIV: begin
        req_legal = 1'b1;
        req_load  = DIV_LOAD;
      end
      default: req_legal = 1'b0;
    endcase
    req_div0 = (req_op == OP_DIV) && (req_b == 16'd0);
  end

  // Result qualification looks at the registered op, since capture happens in EXEC.
  always_comb begin
    cap_ovf  = alu_overflow && ((alu_op == OP_ADD) || (alu_op == OP_SUB) || (alu_op == OP_MUL));
    cap_uvld = (alu_op == OP_DIV) || (alu_op == OP_SWAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      dst_q         <= '0;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      res_valid     <= 1'b0;
      alu_op        <= '0;
      alu_data1     <= '0;
      alu_data2     <= '0;
      res_lower     <= '0;
      res_upper     <= '0;
      res_upper_vld <= 1'b0;
      res_dst       <= '0;
      res_err       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_op    <= req_op;
            alu_data1 <= req_a;
            alu_data2 <= req_b;
            dst_q     <= req_dst;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (!req_legal || req_div0) begin
              state         <= DONE;
              res_valid     <= 1'b1;
              res_lower     <= '0;
              res_upper     <= '0;
              res_upper_vld <= 1'b0;
              res_dst       <= req_dst;
              res_err       <= req_legal ? 2'b10 : 2'b11;
            end else begin
              state <= EXEC;
              cnt   <= req_load;
            end
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            state         <= DONE;
            res_valid     <= 1'b1;
            res_lower     <= cap_ovf ? '0 : alu_lower;
            res_upper     <= cap_uvld ? alu_upper : '0;
            res_upper_vld <= cap_uvld;
            res_dst       <= dst_q;
            res_err       <= cap_ovf ? 2'b01 : 2'b00;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed table-driven bench for alu_sequencer with a behavioural ALU model,
// plus hand-written backpressure and reset-abort sequences.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_dst;
  logic [3:0]  alu_op;
  logic [15:0] alu_data1;
  logic [15:0] alu_data2;
  logic [15:0] alu_upper;
  logic [15:0] alu_lower;
  logic        alu_overflow;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_lower;
  logic [15:0] res_upper;
  logic        res_upper_vld;
  logic [3:0]  res_dst;
  logic [1:0]  res_err;
  logic        busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_dst(req_dst),
    .alu_op(alu_op), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_upper(alu_upper), .alu_lower(alu_lower), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_lower(res_lower), .res_upper(res_upper), .res_upper_vld(res_upper_vld),
    .res_dst(res_dst), .res_err(res_err), .busy(busy)
  );

  // External ALU model; 16'hDEAD on upper for ops without an upper result exposes missing forcing.
  logic [16:0] sum;
  logic [31:0] prod;
  always_comb begin
    alu_lower    = '0;
    alu_upper    = 16'hDEAD;
    alu_overflow = 1'b0;
    sum          = '0;
    prod         = '0;
    case (alu_op)
      4'b0000: begin sum = {1'b0, alu_data1} + {1'b0, alu_data2}; alu_lower = sum[15:0]; alu_overflow = sum[16]; end
      4'b0001: begin sum = {1'b0, alu_data1} - {1'b0, alu_data2}; alu_lower = sum[15:0]; alu_overflow = sum[16]; end
      4'b0100: begin
        prod = alu_data1 * alu_data2;
        alu_lower = prod[15:0]; alu_upper = prod[31:16]; alu_overflow = (prod[31:16] != 16'd0);
      end
      4'b0101: if (alu_data2 != 16'd0) begin alu_lower = alu_data1 / alu_data2; alu_upper = alu_data1 % alu_data2; end
      4'b0111: alu_lower = alu_data1;
      4'b1000: begin alu_lower = alu_data2; alu_upper = alu_data1; end
      4'b1001: alu_lower = alu_data1 & alu_data2;
      4'b1011: alu_lower = alu_data1 | alu_data2;
      default: alu_lower = 16'hBAD0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  dst;
    int          lat;
    logic [15:0] lo;
    logic [15:0] up;
    logic        uv;
    logic [1:0]  err;
  } vec_t;

  vec_t vt[14];

  // Entered and left at posedge+1 with the DUT idle; lat counts edges after the accept edge.
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b; req_dst = v.dst;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk($sformatf("v%0d_alu_op", idx), {28'd0, alu_op}, {28'd0, v.op});
    chk($sformatf("v%0d_alu_data", idx), {alu_data1, alu_data2}, {v.a, v.b});
    n = 0;
    while (!res_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("v%0d_latency", idx), n, v.lat);
    chk($sformatf("v%0d_lower", idx), {16'd0, res_lower}, {16'd0, v.lo});
    chk($sformatf("v%0d_upper", idx), {15'd0, res_upper_vld, res_upper}, {15'd0, v.uv, v.up});
    chk($sformatf("v%0d_err_dst", idx), {26'd0, res_err, res_dst}, {26'd0, v.err, v.dst});
    @(posedge clk); #1;
    chk($sformatf("v%0d_back_idle", idx), {30'd0, res_valid, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{4'b0000, 16'h0003, 16'h0004, 4'd5,  1, 16'h0007, 16'h0000, 1'b0, 2'b00};
    vt[1]  = '{4'b0101, 16'd17,   16'd5,    4'd2,  4, 16'd3,    16'd2,    1'b1, 2'b00};
    vt[2]  = '{4'b0101, 16'h0009, 16'h0000, 4'd3,  0, 16'h0000, 16'h0000, 1'b0, 2'b10};
    vt[3]  = '{4'b0010, 16'h0005, 16'h0006, 4'd4,  0, 16'h0000, 16'h0000, 1'b0, 2'b11};
    vt[4]  = '{4'b0000, 16'hFFFF, 16'h0002, 4'd1,  1, 16'h0000, 16'h0000, 1'b0, 2'b01};
    vt[5]  = '{4'b0001, 16'h000A, 16'h0003, 4'd6,  1, 16'h0007, 16'h0000, 1'b0, 2'b00};
    vt[6]  = '{4'b0100, 16'h0100, 16'h0003, 4'd8,  2, 16'h0300, 16'h0000, 1'b0, 2'b00};
    vt[7]  = '{4'b0100, 16'h1000, 16'h0010, 4'd9,  2, 16'h0000, 16'h0000, 1'b0, 2'b01};
    vt[8]  = '{4'b1000, 16'hAAAA, 16'h5555, 4'd10, 1, 16'h5555, 16'hAAAA, 1'b1, 2'b00};
    vt[9]  = '{4'b1001, 16'hF0F0, 16'h3C3C, 4'd11, 1, 16'h3030, 16'h0000, 1'b0, 2'b00};
    vt[10] = '{4'b1011, 16'hF000, 16'h000F, 4'd12, 1, 16'hF00F, 16'h0000, 1'b0, 2'b00};
    vt[11] = '{4'b0111, 16'hBEEF, 16'h1111, 4'd13, 1, 16'hBEEF, 16'h0000, 1'b0, 2'b00};
    vt[12] = '{4'b0001, 16'h0003, 16'h0005, 4'd14, 1, 16'h0000, 16'h0000, 1'b0, 2'b01};
    vt[13] = '{4'b1111, 16'h1234, 16'h5678, 4'd15, 0, 16'h0000, 16'h0000, 1'b0, 2'b11};

    rst = 1'b1; req_valid = 1'b0; res_ready = 1'b1;
    req_op = '0; req_a = '0; req_b = '0; req_dst = '0;
    #3;
    chk("rst_handshake", {29'd0, req_ready, res_valid, busy}, 32'd4);
    chk("rst_alu", {alu_op, alu_data1[11:0], alu_data2}, 32'd0);
    chk("rst_res", {res_lower, res_upper}, 32'd0);
    chk("rst_res_misc", {25'd0, res_upper_vld, res_dst, res_err}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vt[i], i);

    // Backpressure: result held, req_valid ignored while not idle, then held request taken.
    res_ready = 1'b0;
    req_valid = 1'b1; req_op = 4'b0000; req_a = 16'h0010; req_b = 16'h0020; req_dst = 4'd7;
    @(posedge clk); #1;
    req_op = 4'b0111; req_a = 16'h1234; req_b = 16'h0000; req_dst = 4'd9;
    @(posedge clk); #1;
    chk("bp_valid", {31'd0, res_valid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", c), {res_valid, req_ready, res_err, res_dst, res_lower, res_upper_vld, 7'd0},
          {1'b1, 1'b0, 2'b00, 4'd7, 16'h0030, 1'b0, 7'd0});
      chk($sformatf("bp_alu%0d", c), {28'd0, alu_op}, 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {30'd0, res_valid, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_next_accept", {27'd0, busy, alu_op}, {27'd0, 1'b1, 4'b0111});
    @(posedge clk); #1;
    chk("bp_next_result", {res_valid, 11'd0, res_dst, res_lower}, {1'b1, 11'd0, 4'd9, 16'h1234});
    chk("bp_next_upper", {16'd0, res_upper}, 32'd0);
    @(posedge clk); #1;

    // Reset one cycle into a multiply: no result, immediately idle, accept on first edge after.
    req_valid = 1'b1; req_op = 4'b0100; req_a = 16'h0003; req_b = 16'h0004; req_dst = 4'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mr_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("mr_still_exec", {30'd0, res_valid, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_abort", {29'd0, req_ready, res_valid, busy}, 32'd4);
    chk("mr_cleared", {alu_op, res_dst, res_lower[7:0], alu_data1}, 32'd0);
    @(posedge clk); #1;
    chk("mr_no_result", {30'd0, res_valid, busy}, 32'd0);
    rst = 1'b0;
    req_valid = 1'b1; req_op = 4'b0111; req_a = 16'h00A5; req_b = 16'h0000; req_dst = 4'd6;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mr_accept", {27'd0, busy, alu_op}, {27'd0, 1'b1, 4'b0111});
    chk("mr_accept_nores", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    chk("mr_result", {res_valid, 11'd0, res_dst, res_lower}, {1'b1, 11'd0, 4'd6, 16'h00A5});
    @(posedge clk); #1;
    chk("mr_idle", {30'd0, res_valid, req_ready}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
